// File: rtl/ebpc_zrle_encoder.sv
// Zero/non-zero run-length encoder for the EBPC path. It emits '1' for each non-zero word and
// '0'+run-1 for each zero run, packed MSB-first into DATA_W-bit words, with a frame-end flush.
module ebpc_zrle_encoder #(
  parameter int DATA_W = 8,
  parameter int ZRL_W  = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] data_i,
  input  logic              last_i,
  input  logic              vld_i,
  output logic              rdy_o,
  output logic [DATA_W-1:0] znz_data_o,
  output logic              znz_last_o,
  output logic              znz_vld_o,
  input  logic              znz_rdy_i
);

  localparam int MAX_RUN = 2**ZRL_W;
  localparam int SYM_W   = ZRL_W + 2;
  localparam int ACC_W   = DATA_W + ZRL_W;
  localparam int TW      = DATA_W + SYM_W;
  localparam int FW      = $clog2(DATA_W) + 2;
  localparam logic [ZRL_W:0] RUN_MAX = (ZRL_W+1)'(MAX_RUN);

  // A run symbol plus '1' appended to an almost-full accumulator must never complete two words.
  if (ZRL_W + 2 > DATA_W) begin : g_param_chk
    $error("ebpc_zrle_encoder: ZRL_W+2 must not exceed DATA_W");
  end

  typedef enum logic [1:0] {ENC, FLUSH_RUN, FLUSH_PAD} state_e;

  state_e              state_q, state_d;
  logic [ZRL_W:0]      run_q, run_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [FW-1:0]       fill_q, fill_d;
  logic [DATA_W-1:0]   out_q, out_d;
  logic                out_last_q, out_last_d;
  logic                out_vld_q, out_vld_d;

  logic                out_free, acc_in, zero_w;
  logic [ZRL_W:0]      run_inc;
  logic [ZRL_W-1:0]    run_m1;
  logic [SYM_W-1:0]    sym;
  logic [FW-1:0]       len, nf;
  logic [TW-1:0]       place, tmp;
  logic                app, ld, ld_last;
  logic [DATA_W-1:0]   ld_data;

  assign out_free = !out_vld_q || znz_rdy_i;
  assign rdy_o    = (state_q == ENC) && out_free;
  assign acc_in   = vld_i && rdy_o;
  assign zero_w   = (data_i == '0);
  assign run_inc  = run_q + (ZRL_W+1)'(1);
  // Truncation maps a full run (MAX_RUN) onto the all-ones length field.
  assign run_m1   = run_q[ZRL_W-1:0] - ZRL_W'(1);

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    acc_d   = acc_q;
    fill_d  = fill_q;
    sym     = '0;
    len     = '0;
    app     = 1'b0;
    ld      = 1'b0;
    ld_data = out_q;
    ld_last = 1'b0;
    place   = '0;
    tmp     = '0;
    nf      = '0;

    // Symbols are built left-aligned in sym; len says how many top bits are real.
    case (state_q)
      ENC: if (acc_in) begin
        if (zero_w) begin
          if (!last_i && run_inc == RUN_MAX) begin
            app   = 1'b1;
            sym   = {1'b0, {ZRL_W{1'b1}}, 1'b0};
            len   = FW'(ZRL_W + 1);
            run_d = '0;
          end else begin
            run_d = run_inc;
          end
        end else begin
          app   = 1'b1;
          run_d = '0;
          if (run_q != '0) begin
            sym = {1'b0, run_m1, 1'b1};
            len = FW'(SYM_W);
          end else begin
            sym = {1'b1, {(SYM_W-1){1'b0}}};
            len = FW'(1);
          end
        end
        if (last_i) state_d = FLUSH_RUN;
      end
      FLUSH_RUN: begin
        if (run_q == '0) begin
          state_d = FLUSH_PAD;
        end else if (out_free) begin
          app     = 1'b1;
          sym     = {1'b0, run_m1, 1'b0};
          len     = FW'(ZRL_W + 1);
          run_d   = '0;
          state_d = FLUSH_PAD;
        end
      end
      FLUSH_PAD: begin
        if (fill_q == '0) begin
          state_d = ENC;
        end else if (out_free) begin
          ld      = 1'b1;
          ld_data = acc_q[ACC_W-1 -: DATA_W];
          ld_last = 1'b1;
          acc_d   = '0;
          fill_d  = '0;
          state_d = ENC;
        end
      end
      default: state_d = ENC;
    endcase

    if (app) begin
      place = {sym, {DATA_W{1'b0}}} >> fill_q;
      tmp   = {acc_q, 2'b00} | place;
      nf    = fill_q + len;
      if (nf >= FW'(DATA_W)) begin
        ld      = 1'b1;
        ld_data = tmp[TW-1 -: DATA_W];
        acc_d   = {tmp[SYM_W-1:0], {(DATA_W-2){1'b0}}};
        fill_d  = nf - FW'(DATA_W);
        // Frame closes exactly on a word boundary: tag this word, nothing left to flush.
        if (fill_d == '0 && run_d == '0 && (state_q == FLUSH_RUN || last_i)) begin
          ld_last = 1'b1;
          state_d = ENC;
        end
      end else begin
        acc_d  = tmp[TW-1 -: ACC_W];
        fill_d = nf;
      end
    end

    out_d      = ld ? ld_data : out_q;
    out_last_d = ld ? ld_last : out_last_q;
    out_vld_d  = ld | (out_vld_q & ~znz_rdy_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ENC;
      run_q      <= '0;
      acc_q      <= '0;
      fill_q     <= '0;
      out_q      <= '0;
      out_last_q <= 1'b0;
      out_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      acc_q      <= acc_d;
      fill_q     <= fill_d;
      out_q      <= out_d;
      out_last_q <= out_last_d;
      out_vld_q  <= out_vld_d;
    end
  end

  assign znz_data_o = out_q;
  assign znz_last_o = out_last_q;
  assign znz_vld_o  = out_vld_q;

endmodule

// File: tb/tb_ebpc_zrle_encoder.sv
// Bench for ebpc_zrle_encoder: a bit-stream reference model fills an expectation queue per frame,
// and an output monitor pops and compares every accepted packed word.
module tb_ebpc_zrle_encoder;
  localparam int DW   = 8;
  localparam int ZW   = 4;
  localparam int MAXR = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic          last_i = 1'b0;
  logic          vld_i = 1'b0;
  logic          rdy_o;
  logic [DW-1:0] znz_data_o;
  logic          znz_last_o;
  logic          znz_vld_o;
  logic          znz_rdy_i = 1'b1;

  ebpc_zrle_encoder #(.DATA_W(DW), .ZRL_W(ZW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .data_i(data_i), .last_i(last_i), .vld_i(vld_i),
    .rdy_o(rdy_o), .znz_data_o(znz_data_o), .znz_last_o(znz_last_o),
    .znz_vld_o(znz_vld_o), .znz_rdy_i(znz_rdy_i)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed { logic [DW-1:0] d; logic l; } exp_t;
  exp_t          exp_q[$];
  logic [DW-1:0] frm_q[$];
  int            n_chk = 0;
  int            n_pass = 0;
  bit            rnd_rdy = 1'b0;

  // Reference: serialise the frame into symbol bits, then chop into zero-padded words.
  task automatic model_frame();
    bit bits[$];
    int run;
    exp_t e;
    run = 0;
    foreach (frm_q[i]) begin
      if (frm_q[i] == '0) begin
        run++;
        if (run == MAXR && i != frm_q.size() - 1) begin
          bits.push_back(1'b0);
          for (int b = ZW - 1; b >= 0; b--) bits.push_back(bit'((run - 1) >> b));
          run = 0;
        end
      end else begin
        if (run > 0) begin
          bits.push_back(1'b0);
          for (int b = ZW - 1; b >= 0; b--) bits.push_back(bit'((run - 1) >> b));
        end
        bits.push_back(1'b1);
        run = 0;
      end
    end
    if (run > 0) begin
      bits.push_back(1'b0);
      for (int b = ZW - 1; b >= 0; b--) bits.push_back(bit'((run - 1) >> b));
    end
    while (bits.size() > 0) begin
      e.d = '0;
      for (int b = 0; b < DW; b++) if (bits.size() > 0) e.d[DW-1-b] = bits.pop_front();
      e.l = (bits.size() == 0);
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_word(input logic [DW-1:0] d, input logic l);
    int c;
    data_i = d; last_i = l; vld_i = 1'b1;
    c = 0;
    @(negedge clk);
    while (!rdy_o && c < 500) begin @(negedge clk); c++; end
    if (!rdy_o) begin
      n_chk++;
      $display("FAIL input_accept: rdy_o stayed %b, required 1 within 500 cycles", rdy_o);
    end
    @(posedge clk); #1;
    vld_i = 1'b0; data_i = '0; last_i = 1'b0;
  endtask

  task automatic send_frame(input bit use_model, input bit with_last, input bit gaps);
    if (use_model) model_frame();
    foreach (frm_q[i]) begin
      drive_word(frm_q[i], with_last && (i == frm_q.size() - 1));
      if (gaps && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    frm_q.delete();
  endtask

  task automatic wait_drain(input string name);
    int c;
    c = 0;
    while (exp_q.size() > 0 && c < 400) begin @(negedge clk); c++; end
    repeat (4) @(negedge clk);
    n_chk++;
    if (exp_q.size() != 0) $display("FAIL drain_%s: %0d words pending, required 0", name, exp_q.size());
    else n_pass++;
    @(posedge clk); #1;
  endtask

  // Output monitor: compares accepted words and checks held words stay stable.
  initial begin
    logic [DW-1:0] hd;
    logic hl;
    bit hold;
    exp_t e;
    hold = 1'b0; hd = '0; hl = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          n_chk++;
          if (znz_vld_o !== 1'b1 || znz_data_o !== hd || znz_last_o !== hl)
            $display("FAIL hold_stable: got vld=%b data=%h last=%b, required vld=1 data=%h last=%b",
                     znz_vld_o, znz_data_o, znz_last_o, hd, hl);
          else n_pass++;
        end
        if (znz_vld_o && znz_rdy_i) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_out: got data=%h last=%b, required no output", znz_data_o, znz_last_o);
          end else begin
            e = exp_q.pop_front();
            n_chk++;
            if (znz_data_o !== e.d) $display("FAIL out_data: got %h, required %h", znz_data_o, e.d);
            else n_pass++;
            n_chk++;
            if (znz_last_o !== e.l) $display("FAIL out_last: got %b, required %b (data %h)", znz_last_o, e.l, e.d);
            else n_pass++;
          end
          hold = 1'b0;
        end else if (znz_vld_o) begin
          hold = 1'b1; hd = znz_data_o; hl = znz_last_o;
        end else begin
          hold = 1'b0;
        end
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rnd_rdy) znz_rdy_i = ($urandom_range(0, 3) != 0);
  end

  task automatic check_idle(input string name);
    n_chk++;
    if (znz_vld_o !== 1'b0) $display("FAIL %s_vld: got %b, required 0", name, znz_vld_o); else n_pass++;
    n_chk++;
    if (znz_data_o !== '0) $display("FAIL %s_data: got %h, required 00", name, znz_data_o); else n_pass++;
    n_chk++;
    if (znz_last_o !== 1'b0) $display("FAIL %s_last: got %b, required 0", name, znz_last_o); else n_pass++;
    n_chk++;
    if (rdy_o !== 1'b1) $display("FAIL %s_rdy: got %b, required 1", name, rdy_o); else n_pass++;
  endtask

  task automatic test_reset();
    #3;
    check_idle("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_all_nonzero();
    for (int i = 0; i < 8; i++) frm_q.push_back(DW'($urandom_range(1, 255)));
    send_frame(1'b1, 1'b1, 1'b0);
    wait_drain("all_nonzero");
  endtask

  task automatic test_short_run();
    frm_q = '{8'h00, 8'h00, 8'h00, 8'h05};
    send_frame(1'b1, 1'b1, 1'b0);
    wait_drain("short_run");
  endtask

  task automatic test_max_run();
    for (int i = 0; i < 17; i++) frm_q.push_back(8'h00);
    send_frame(1'b1, 1'b1, 1'b0);
    wait_drain("max_run");
  endtask

  task automatic test_mixed();
    frm_q = '{8'h00, 8'h00, 8'h11, 8'h00, 8'h00};
    send_frame(1'b1, 1'b1, 1'b0);
    wait_drain("mixed");
  endtask

  task automatic test_backpressure();
    int c;
    bit saw_rdy;
    for (int i = 0; i < 12; i++) frm_q.push_back(DW'($urandom_range(1, 255)));
    znz_rdy_i = 1'b0;
    fork
      send_frame(1'b1, 1'b1, 1'b0);
      begin
        c = 0;
        while (!znz_vld_o && c < 100) begin @(negedge clk); c++; end
        saw_rdy = 1'b0;
        repeat (20) begin @(negedge clk); if (rdy_o) saw_rdy = 1'b1; end
        n_chk++;
        if (!znz_vld_o || saw_rdy)
          $display("FAIL bp_stall: got vld=%b rdy_seen=%b, required vld=1 rdy_seen=0", znz_vld_o, saw_rdy);
        else n_pass++;
        @(posedge clk); #1;
        znz_rdy_i = 1'b1;
      end
    join
    wait_drain("backpressure");
  endtask

  task automatic test_back_to_back();
    int n;
    rnd_rdy = 1'b1;
    for (int f = 0; f < 8; f++) begin
      n = $urandom_range(1, 30);
      if (f == 3) begin
        for (int i = 0; i < 40; i++) frm_q.push_back(8'h00);
        frm_q.push_back(8'h80);
      end
      for (int i = 0; i < n; i++)
        frm_q.push_back(($urandom_range(0, 9) < 6) ? 8'h00 : DW'($urandom_range(1, 255)));
      send_frame(1'b1, 1'b1, 1'b1);
    end
    wait_drain("back_to_back");
    rnd_rdy = 1'b0;
    znz_rdy_i = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    // Leaves three '1' bits in the accumulator and a pending run of five zeros.
    frm_q = '{8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_idle("reset_mid");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) frm_q.push_back(8'h01);
    send_frame(1'b1, 1'b1, 1'b0);
    wait_drain("after_reset");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_all_nonzero();
    test_short_run();
    test_max_run();
    test_mixed();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
